// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key 2-flop synchroniser followed by a debounce FSM
// that produces a clean level, press/release strobes and optional auto-repeat presses.
module key_conditioner #(
    parameter int unsigned NKEYS    = 4,
    parameter int unsigned DEBOUNCE = 500000,
    parameter int unsigned REPEAT   = 0,
    parameter int unsigned CNT_W    = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_n,
    output logic [NKEYS-1:0] level,
    output logic [NKEYS-1:0] press,
    output logic [NKEYS-1:0] released
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] REP_LAST = (REPEAT == 0) ? '0 : CNT_W'(REPEAT - 1);
    localparam logic             REP_EN   = (REPEAT != 0);

    logic [NKEYS-1:0] sync1;
    logic [NKEYS-1:0] sync2;
    state_t           state [NKEYS];
    logic [CNT_W-1:0] cnt   [NKEYS];
    logic [CNT_W-1:0] rcnt  [NKEYS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1    <= '1;
            sync2    <= '1;
            level    <= '0;
            press    <= '0;
            released <= '0;
            for (int i = 0; i < int'(NKEYS); i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
                rcnt[i]  <= '0;
            end
        end else begin
            sync1    <= key_n;
            sync2    <= sync1;
            press    <= '0;
            released <= '0;
            for (int i = 0; i < int'(NKEYS); i++) begin
                // sync2 is active-low: a 0 means the key is currently pressed
                case (state[i])
                    IDLE: begin
                        if (!sync2[i]) begin
                            state[i] <= PRESS_WAIT;
                            cnt[i]   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (sync2[i]) begin
                            state[i] <= IDLE;
                        end else if (cnt[i] == DEB_LAST) begin
                            state[i] <= HELD;
                            level[i] <= 1'b1;
                            press[i] <= 1'b1;
                            rcnt[i]  <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (sync2[i]) begin
                            state[i] <= RELEASE_WAIT;
                            cnt[i]   <= '0;
                        end else if (REP_EN && rcnt[i] == REP_LAST) begin
                            press[i] <= 1'b1;
                            rcnt[i]  <= '0;
                        end else if (REP_EN) begin
                            rcnt[i] <= rcnt[i] + CNT_W'(1);
                        end
                    end
                    RELEASE_WAIT: begin
                        // A bounce back to pressed resumes HELD with the repeat count intact
                        if (!sync2[i]) begin
                            state[i] <= HELD;
                        end else if (cnt[i] == DEB_LAST) begin
                            state[i]    <= IDLE;
                            level[i]    <= 1'b0;
                            released[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus pushes expected press/release
// events (channel, kind, cycle); a negedge monitor pops and checks every pulse.
module tb_key_conditioner;

    localparam int unsigned NKEYS = 4;

    typedef struct {
        bit          is_press;
        int unsigned cyc;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [NKEYS-1:0] key_n;
    logic [NKEYS-1:0] level;
    logic [NKEYS-1:0] press;
    logic [NKEYS-1:0] released;

    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    ev_t         exp_q [NKEYS][$];

    key_conditioner #(
        .NKEYS   (NKEYS),
        .DEBOUNCE(4),
        .REPEAT  (6),
        .CNT_W   (20)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key_n   (key_n),
        .level   (level),
        .press   (press),
        .released(released)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int ch, input bit is_press, input int unsigned at);
        ev_t e;
        e.is_press = is_press;
        e.cyc      = at;
        exp_q[ch].push_back(e);
    endtask

    task automatic check_ev(input int ch, input bit is_press);
        ev_t e;
        tests++;
        if (exp_q[ch].size() == 0) begin
            fails++;
            $display("FAIL unexpected_%s ch%0d: pulse at cycle %0d, none expected",
                     is_press ? "press" : "release", ch, cyc);
        end else begin
            e = exp_q[ch].pop_front();
            if (e.is_press != is_press || e.cyc != cyc) begin
                fails++;
                $display("FAIL event ch%0d: got %s at cycle %0d expected %s at cycle %0d",
                         ch, is_press ? "press" : "release", cyc,
                         e.is_press ? "press" : "release", e.cyc);
            end
        end
        chk($sformatf("level_at_event ch%0d", ch), 32'(level[ch]), 32'(is_press));
    endtask

    // Monitor: every pulse must match the head of that channel's expectation queue
    always @(negedge clk) begin
        for (int ch = 0; ch < int'(NKEYS); ch++) begin
            if (press[ch] && released[ch]) begin
                tests++;
                fails++;
                $display("FAIL both_pulses ch%0d: press and release together at cycle %0d", ch, cyc);
            end
            if (press[ch])    check_ev(ch, 1'b1);
            if (released[ch]) check_ev(ch, 1'b0);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned t0;

        reset = 1'b0;
        key_n = '1;
        tick(2);

        // Reset held with all keys pressed: outputs stay quiet
        key_n = '0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("reset_quiet", 32'({level, press, released}), 32'h0);
        end
        t0    = cyc;
        reset = 1'b1;
        for (int ch = 0; ch < int'(NKEYS); ch++) expect_ev(ch, 1'b1, t0 + 7);
        tick(7);
        chk("level_after_reset", 32'(level), 32'hF);
        tick(1);
        key_n = '1;
        for (int ch = 0; ch < int'(NKEYS); ch++) expect_ev(ch, 1'b0, cyc + 7);
        tick(10);
        chk("level_all_released", 32'(level), 32'h0);

        // Clean press and release on key 0
        t0       = cyc;
        key_n[0] = 1'b0;
        expect_ev(0, 1'b1, t0 + 7);
        tick(9);
        key_n[0] = 1'b1;
        expect_ev(0, 1'b0, t0 + 16);
        tick(12);

        // Bounce on key 1: never accepted
        key_n[1] = 1'b0; tick(3);
        key_n[1] = 1'b1; tick(1);
        key_n[1] = 1'b0; tick(3);
        key_n[1] = 1'b1; tick(12);
        chk("bounce_level", 32'(level[1]), 32'h0);

        // Release glitch on key 2: single release after the final release
        t0       = cyc;
        key_n[2] = 1'b0;
        expect_ev(2, 1'b1, t0 + 7);
        tick(9);
        key_n[2] = 1'b1; tick(2);
        key_n[2] = 1'b0; tick(2);
        key_n[2] = 1'b1;
        expect_ev(2, 1'b0, t0 + 20);
        tick(12);

        // Auto-repeat on key 3
        t0       = cyc;
        key_n[3] = 1'b0;
        expect_ev(3, 1'b1, t0 + 7);
        expect_ev(3, 1'b1, t0 + 13);
        expect_ev(3, 1'b1, t0 + 19);
        expect_ev(3, 1'b1, t0 + 25);
        tick(28);
        chk("repeat_level_held", 32'(level[3]), 32'h1);
        key_n[3] = 1'b1;
        expect_ev(3, 1'b0, t0 + 35);
        tick(12);

        // Reset in the middle of a press debounce on key 0
        t0       = cyc;
        key_n[0] = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(1);
        chk("mid_reset_quiet", 32'({level, press, released}), 32'h0);
        tick(1);
        reset = 1'b1;
        expect_ev(0, 1'b1, cyc + 7);
        tick(6);
        chk("mid_reset_not_yet", 32'(level[0]), 32'h0);
        tick(2);
        key_n[0] = 1'b1;
        expect_ev(0, 1'b0, cyc + 7);
        tick(12);

        for (int ch = 0; ch < int'(NKEYS); ch++)
            chk($sformatf("queue_drained ch%0d", ch), 32'(exp_q[ch].size()), 32'h0);
        chk("final_level", 32'(level), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
